read_serializer: RTL and testbench

READ_SERIALIZER -- requirements
Module: read_serializer

---
 rtl/read_serializer_if.sv | 31 +++
 rtl/read_serializer.sv | 110 +++++++++++
 tb/tb_read_serializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/read_serializer_if.sv
// Handshake bundle between a FIFO read port, the read serializer and its serial consumer.
// The master modport is the serializer's view; the slave modport is the surrounding FIFO/consumer.
interface read_serializer_if #(
    parameter int NUM_BIT  = 4,
    parameter int PAR_READ = 2
);
    logic [PAR_READ*NUM_BIT-1:0] fifo_dout;
    logic                        fifo_valid;
    logic                        fifo_ren;
    logic [NUM_BIT-1:0]          out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        input  fifo_dout,
        input  fifo_valid,
        output fifo_ren,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output fifo_dout,
        output fifo_valid,
        input  fifo_ren,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/read_serializer.sv
// Splits PAR_READ-item FIFO words into a serial item stream, lane 0 first, with no bubble between words.
// Optional feature: define SER_WORD_COUNT_EN to add a saturating 16-bit count of popped words.
module read_serializer #(
    parameter int NUM_BIT  = 4,
    parameter int PAR_READ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    read_serializer_if.master  bus
`ifdef SER_WORD_COUNT_EN
    ,
    output logic [15:0]        word_count
`endif
);

    localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                      r_state;
    logic [PAR_READ*NUM_BIT-1:0] r_word;
    logic [IDX_W-1:0]            r_idx;

    logic                        w_last;
    logic                        w_xfer;
    logic                        w_ren;
    logic [NUM_BIT-1:0]          w_lane;

    assign w_last = (r_idx == LAST_IDX);
    assign w_xfer = (r_state == SEND) && bus.out_ready;

    // Pop in IDLE, or on the final-lane transfer so the next word follows without a gap.
    always_comb begin
        w_ren = 1'b0;
        if (!rst && !init) begin
            if (r_state == IDLE)
                w_ren = bus.fifo_valid;
            else
                w_ren = w_xfer && w_last && bus.fifo_valid;
        end
    end

    always_comb begin
        w_lane = '0;
        for (int k = 0; k < PAR_READ; k++) begin
            if (r_idx == IDX_W'(k))
                w_lane = r_word[k*NUM_BIT +: NUM_BIT];
        end
    end

    assign bus.fifo_ren  = w_ren;
    assign bus.out_valid = (r_state == SEND);
    assign bus.out_data  = (r_state == SEND) ? w_lane : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
        end else if (init) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ren) begin
                        r_word  <= bus.fifo_dout;
                        r_idx   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (!w_last) begin
                            r_idx <= r_idx + 1'b1;
                        end else if (bus.fifo_valid) begin
                            r_word <= bus.fifo_dout;
                            r_idx  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SER_WORD_COUNT_EN
    logic [15:0] r_word_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_word_count <= '0;
        else if (init)
            r_word_count <= '0;
        else if (w_ren && (r_word_count != 16'hFFFF))
            r_word_count <= r_word_count + 16'd1;
    end

    assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_read_serializer.sv
// Directed bench for read_serializer (NUM_BIT=4, PAR_READ=2); build with SER_WORD_COUNT_EN to cover word_count.
module tb_read_serializer;

    logic clk = 1'b0;
    logic rst;
    logic init;
`ifdef SER_WORD_COUNT_EN
    logic [15:0] word_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    read_serializer_if #(.NUM_BIT(4), .PAR_READ(2)) bus ();

    read_serializer #(.NUM_BIT(4), .PAR_READ(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .bus  (bus)
`ifdef SER_WORD_COUNT_EN
        ,
        .word_count (word_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [3:0] od, input logic ren);
        check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check_eq({tag, ".out_data"},  32'(bus.out_data),  32'(od));
        check_eq({tag, ".fifo_ren"},  32'(bus.fifo_ren),  32'(ren));
    endtask

    task automatic drive(input logic fv, input logic [7:0] dout, input logic rdy, input logic ini);
        bus.fifo_valid = fv;
        bus.fifo_dout  = dout;
        bus.out_ready  = rdy;
        init           = ini;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_count(input string tag, input int exp);
`ifdef SER_WORD_COUNT_EN
        check_eq(tag, 32'(word_count), 32'(exp));
`endif
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        next_cycle();
        // Reset state, with fifo_valid high to prove fifo_ren is gated.
        check_out("reset", 1'b0, 4'h0, 1'b0);
        check_count("reset.word_count", 0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_out("idle", 1'b0, 4'h0, 1'b0);
        next_cycle();

        // Single word 0xA5
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        check_out("single.c0", 1'b0, 4'h0, 1'b1);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_out("single.c1", 1'b1, 4'h5, 1'b0);
        next_cycle();
        check_out("single.c2", 1'b1, 4'hA, 1'b0);
        next_cycle();
        check_out("single.c3", 1'b0, 4'h0, 1'b0);
        next_cycle();

        // Back-to-back 0x21, 0x43
        drive(1'b1, 8'h21, 1'b1, 1'b0);
        check_out("b2b.c0", 1'b0, 4'h0, 1'b1);
        next_cycle();
        drive(1'b1, 8'h43, 1'b1, 1'b0);
        check_out("b2b.c1", 1'b1, 4'h1, 1'b0);
        next_cycle();
        check_out("b2b.c2", 1'b1, 4'h2, 1'b1);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_out("b2b.c3", 1'b1, 4'h3, 1'b0);
        next_cycle();
        check_out("b2b.c4", 1'b1, 4'h4, 1'b0);
        next_cycle();
        check_out("b2b.c5", 1'b0, 4'h0, 1'b0);
        check_count("b2b.word_count", 3);
        next_cycle();

        // Backpressure on 0xC7
        drive(1'b1, 8'hC7, 1'b1, 1'b0);
        check_out("bp.c0", 1'b0, 4'h0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            check_out($sformatf("bp.hold%0d", i), 1'b1, 4'h7, 1'b0);
        end
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_out("bp.c4", 1'b1, 4'h7, 1'b0);
        next_cycle();
        // Last lane stalled with a word waiting: no pop until the item is taken.
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        check_out("bp.c5", 1'b1, 4'hC, 1'b0);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_out("bp.c6", 1'b1, 4'hC, 1'b0);
        next_cycle();
        check_out("bp.c7", 1'b0, 4'h0, 1'b0);
        next_cycle();

        // init while lane 1 of 0xE9 pending
        drive(1'b1, 8'hE9, 1'b1, 1'b0);
        check_out("init.c0", 1'b0, 4'h0, 1'b1);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_out("init.c1", 1'b1, 4'h9, 1'b0);
        next_cycle();
        drive(1'b1, 8'h3B, 1'b1, 1'b1);
        check_out("init.c2", 1'b1, 4'hE, 1'b0);
        next_cycle();
        drive(1'b1, 8'h3B, 1'b1, 1'b0);
        check_out("init.c3", 1'b0, 4'h0, 1'b1);
        check_count("init.word_count", 0);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_out("init.c4", 1'b1, 4'hB, 1'b0);
        check_count("init.word_count2", 1);
        next_cycle();
        check_out("init.c5", 1'b1, 4'h3, 1'b0);
        next_cycle();
        check_out("init.c6", 1'b0, 4'h0, 1'b0);
        next_cycle();

        // Asynchronous reset mid-SEND
        drive(1'b1, 8'h5D, 1'b1, 1'b0);
        check_out("rst.c0", 1'b0, 4'h0, 1'b1);
        next_cycle();
        drive(1'b1, 8'h5D, 1'b0, 1'b0);
        check_out("rst.c1", 1'b1, 4'hD, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_out("rst.async", 1'b0, 4'h0, 1'b0);
        check_count("rst.word_count", 0);
        next_cycle();
        check_out("rst.held", 1'b0, 4'h0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 8'h5D, 1'b1, 1'b0);
        check_out("rst.release", 1'b0, 4'h0, 1'b1);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check_out("rst.restart", 1'b1, 4'hD, 1'b0);
        check_count("rst.word_count2", 1);
        next_cycle();
        check_out("rst.lane1", 1'b1, 4'h5, 1'b0);
        next_cycle();
        check_out("rst.done", 1'b0, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
